// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Digit-serial adder: computes a + b + cin over WIDTH bits, DIGIT bits per
// clock, through a DIGIT-wide ripple of full-adder cells whose carry-out is
// registered between digits. Valid/ready handshakes on both sides let it sit
// between pipeline stages and trade latency (WIDTH/DIGIT cycles) for area.
//
// Parameters:
//   WIDTH  operand/sum width in bits (>= 2)
//   DIGIT  bits processed per clock (must divide WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operands a, b, cin are valid
//   in_ready   block can accept operands (IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry-in
//   sub        (only with SERIAL_ADDER_SUB_EN) 1 = compute a - b
//   out_valid  sum, cout, ovf are valid (DONE)
//   out_ready  downstream accepts the result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of the MSB
//   ovf        two's-complement overflow
//   busy       high while an operation is in flight or waiting to drain
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub input. With it
// undefined the block only adds and behaves exactly as if sub were tied 0.
// ---------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   // Reject configurations that cannot be cut into whole digits.
   if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_paramCheck
      $error("serial_adder: WIDTH must be >= 2 and divisible by DIGIT");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_stateNext;
   logic [WIDTH-1:0] r_aShift;
   logic [WIDTH-1:0] r_bShift;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [CW-1:0]    r_count;
   logic             r_cout;
   logic             r_ovf;
   logic             w_accept;
   logic             w_lastDigit;
   logic             w_subIn;
   logic             w_subOp;
   logic [DIGIT-1:0] w_bEff;
   logic [DIGIT-1:0] w_digitSum;
   logic [DIGIT:0]   w_carry;
   logic [WIDTH-1:0] w_sumNext;

`ifdef SERIAL_ADDER_SUB_EN
   logic r_sub;
   assign w_subIn = sub;
   assign w_subOp = r_sub;
`else
   assign w_subIn = 1'b0;
   assign w_subOp = 1'b0;
`endif

   assign w_accept    = in_valid & in_ready;
   assign w_lastDigit = (r_count == CW'(N - 1));

   // New digit results enter at the top of the sum register, so after N
   // shifts the first (least significant) digit has reached bit 0.
   assign w_sumNext = (r_sum >> DIGIT) | (WIDTH'(w_digitSum) << (WIDTH - DIGIT));

   // Digit adder: a ripple of DIGIT full-adder cells fed by the registered
   // carry. For subtraction B is inverted on its way into the cells; the
   // +1 of the two's complement was already folded into the initial carry.
   always_comb begin
      w_bEff     = r_bShift[DIGIT-1:0] ^ {DIGIT{w_subOp}};
      w_digitSum = '0;
      w_carry    = '0;
      w_carry[0] = r_carry;
      for (int i = 0; i < DIGIT; i++) begin
         w_digitSum[i] = r_aShift[i] ^ w_bEff[i] ^ w_carry[i];
         w_carry[i+1]  = (r_aShift[i] & w_bEff[i]) |
                         (w_carry[i] & (r_aShift[i] ^ w_bEff[i]));
      end
   end

   // State register; reset wins over any handshake on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state and handshake outputs. The handshake flags depend only on
   // the state so that neither side sees a combinational path through us.
   always_comb begin
      w_stateNext = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               w_stateNext = RUN;
            end
         end
         RUN: begin
            if (w_lastDigit) begin
               w_stateNext = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Datapath: operands are captured only on the accepting edge, then
   // shifted right one digit per cycle. cout and ovf are written only on
   // the final digit, so they stay frozen through DONE and after draining.
   // In the last digit the carry into the top cell is the carry into bit
   // WIDTH-1, which gives the signed overflow directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_aShift <= '0;
         r_bShift <= '0;
         r_sum    <= '0;
         r_carry  <= 1'b0;
         r_count  <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
         r_sub    <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_aShift <= a;
                  r_bShift <= b;
                  r_carry  <= cin ^ w_subIn;
                  r_count  <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                  r_sub    <= sub;
`endif
               end
            end
            RUN: begin
               r_aShift <= r_aShift >> DIGIT;
               r_bShift <= r_bShift >> DIGIT;
               r_sum    <= w_sumNext;
               r_carry  <= w_carry[DIGIT];
               r_count  <= r_count + CW'(1);
               if (w_lastDigit) begin
                  r_cout <= w_carry[DIGIT];
                  r_ovf  <= w_carry[DIGIT-1] ^ w_carry[DIGIT];
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit full_adder cell.
- Adds two WIDTH-bit operands plus a carry-in, processing DIGIT bits per clock. The datapath is a DIGIT-wide ripple of full-adder cells with a registered carry between digits.
- Uses valid/ready handshakes on both input and output, so it can sit between FPGA datapath stages and trade latency for LUT area.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per clock; must divide WIDTH exactly. Violation is flagged by an elaboration-time $error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  sum, cout and ovf are valid
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  result, a + b + cin, modulo 2^WIDTH
- cout  output  1  carry out of the MSB
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB
- busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high on rst, sampled at the rising edge of clk.
- Reset state:
  - State goes to IDLE.
  - in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, busy=0.
  - Internal shift registers and the carry register are cleared.
- Constants:
  - N = WIDTH/DIGIT.
  - Processing cycles per operation = N.
- IDLE:
  - in_ready=1 (driven combinationally from state); busy=0.
  - On an edge with in_valid & in_ready: latch a, b and cin; go to RUN with digit counter = 0.
- RUN:
  - in_ready=0; out_valid=0; busy=1.
  - Each edge adds the low DIGIT bits of the A and B shift registers plus the carry register.
  - The DIGIT result bits shift in at the top of the sum register; A and B shift right by DIGIT.
  - The carry register takes the digit carry-out.
  - The counter increments; on the edge where counter == N-1:
    - state goes to DONE and out_valid becomes 1;
    - cout is set to the final carry;
    - ovf is set to (carry into bit WIDTH-1) XOR cout, computed within the last digit.
- Latency:
  - out_valid rises exactly N edges after the accepting edge.
  - WIDTH=8, DIGIT=1: 8 cycles. WIDTH=8, DIGIT=4: 2 cycles.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are held stable until an edge with out_ready=1.
  - On that edge: out_valid goes to 0, state goes to IDLE, in_ready=1 from the next cycle.
  - sum, cout and ovf keep their last values after the handshake; they are only meaningful while out_valid is high.
- Back-pressure:
  - out_ready may stay low indefinitely; all outputs are frozen.
  - in_valid is ignored while in_ready=0, and no operands are captured.
- No overlap: a new operation cannot be accepted in the same cycle a result is drained; the minimum initiation interval is N+2 cycles.
- Input stability: a, b and cin are sampled only on the accepting edge; later changes have no effect.
- Reset mid-operation: rst in RUN or DONE aborts the operation. Outputs return to their reset values on that edge, and the pending result is discarded without being presented.
- rst has priority over every handshake occurring on the same edge.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the unsigned carry; ovf is the signed overflow indication. Both are produced together.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port sub (1 bit), latched on the accepting edge.
  - When sub=1, the B operand is bit-inverted as it enters the adder cells, and the initial carry is cin XOR 1. With cin=0 this gives a − b.
  - cout=1 means no borrow; ovf follows the same formula.
  - Latency is unchanged.
- Not defined:
  - No sub port; the block only adds.
  - Logic is identical to sub tied to 0.

Test Plan:
- Minimal add, WIDTH=8, DIGIT=1: a=0x00, b=0x00, cin=1 → out_valid exactly 8 cycles after accept; sum=0x01, cout=0, ovf=0.
- Full carry ripple, WIDTH=8, DIGIT=1: a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
- Signed overflow at DIGIT=4, WIDTH=8: a=0x7F, b=0x01, cin=0 → out_valid 2 cycles after accept; sum=0x80, cout=0, ovf=1.
- Back-pressure:
  - Hold out_ready=0 for 5 cycles after out_valid rises → sum, cout and out_valid stay stable and in_ready stays 0.
  - A pulse on in_valid during that window is not captured.
  - Raising out_ready → in_ready=1 on the following cycle.
- Reset mid-operation:
  - Accept a=0x12, b=0x34, then assert rst on the 3rd RUN cycle → next cycle in_ready=1, out_valid=0, sum=0, busy=0.
  - A new operation a=0x01, b=0x01 then completes with sum=0x02.
- With SERIAL_ADDER_SUB_EN defined: sub=1, a=0x05, b=0x07, cin=0 → sum=0xFE, cout=0 (borrow). Then sub=1, a=0x80, b=0x01 → sum=0x7F, ovf=1.
